// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory request per load/store and returns one result to WB.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        we_reg, we_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] resp_data_reg, resp_data_next;
  logic        err_reg, err_next;
  logic        pass_valid_reg, pass_valid_next;
  logic [31:0] pass_data_reg, pass_data_next;

  logic        is_mem_op;
  logic        misaligned;

  assign is_mem_op = mem_read | mem_write;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = (alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      we_reg         <= 1'b0;
      cnt_reg        <= '0;
      resp_data_reg  <= '0;
      err_reg        <= 1'b0;
      pass_valid_reg <= 1'b0;
      pass_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      we_reg         <= we_next;
      cnt_reg        <= cnt_next;
      resp_data_reg  <= resp_data_next;
      err_reg        <= err_next;
      pass_valid_reg <= pass_valid_next;
      pass_data_reg  <= pass_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    we_next         = we_reg;
    cnt_next        = cnt_reg;
    resp_data_next  = resp_data_reg;
    err_next        = err_reg;
    pass_valid_next = 1'b0;
    pass_data_next  = pass_data_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (is_mem_op) begin
            addr_next  = alu_result;
            wdata_next = store_data;
            we_next    = mem_write;
            cnt_next   = '0;
            // Stores and traps report the address; loads overwrite this on ack.
            resp_data_next = (mem_write || misaligned) ? alu_result : 32'h0;
            err_next   = misaligned;
            state_next = misaligned ? RESP : REQ;
          end else begin
            pass_valid_next = 1'b1;
            pass_data_next  = alu_result;
          end
        end
      end
      REQ: begin
        // An ack on the last allowed cycle wins over the timeout.
        if (mem_ack) begin
          if (!we_reg) resp_data_next = mem_rdata;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so async reset drops them at once.
  assign stall     = (state_reg != IDLE);
  assign mem_req   = (state_reg == REQ);
  assign mem_we    = (state_reg == REQ) & we_reg;
  assign mem_addr  = {addr_reg[31:2], 2'b00};
  assign mem_wdata = wdata_reg;
  assign out_valid = (state_reg == RESP) | pass_valid_reg;
  assign out_data  = (state_reg == RESP) ? resp_data_reg : pass_data_reg;
  assign out_err   = (state_reg == RESP) & err_reg;

endmodule
